alu_issue_scheduler: RTL and testbench
======================================

// Module: alu_issue_scheduler
// PURPOSE
//   Reservation station and issue scheduler in front of the shared integer ALU.
//   Holds up to RS_SIZE dispatched ops and tracks operand tags, capturing values from two CDB ports.
//   Each cycle it selects one operand-ready entry and drives it into the ALU through registered issue outputs.
//   Sits between the dispatcher and the ALU; the ALU result returns to it via the ALU CDB port.
// PARAMETERS
//   RS_SIZE    8   number of entries (power of 2, >=2)
//   ROB_IDX_W  4   ROB index width (tag width)
//   OP_W       6   width of the opcode enum
//   XLEN       32  data/address width
// PORTS
//   clk_in              in   1        clock
//   rst_in              in   1        async active-low reset
//   rdy_in              in   1        global enable; low = freeze all state
//   clr_in              in   1        sync flush (mispredict)
//   disp_valid          in   1        dispatch an op this cycle
//   disp_op             in   OP_W     opcode enum
//   disp_vj / disp_vk   in   XLEN     operand values (valid when tag invalid)
//   disp_qj_v/disp_qk_v in   1        operand still pending on tag
//   disp_qj / disp_qk   in   ROB_IDX_W  pending producer ROB index
//   disp_imm, disp_pc   in   XLEN     immediate, instruction PC
//   disp_rob_index      in   ROB_IDX_W  destination ROB index
//   rs_full             out  1        all entries busy (registered state, combinational out)
//   cdb_alu_valid       in   1        ALU broadcast valid
//   cdb_alu_rob_index   in   ROB_IDX_W  ALU broadcast tag
//   cdb_alu_value       in   XLEN     ALU broadcast value
//   cdb_lsb_valid/_rob_index/_value  in  1/ROB_IDX_W/XLEN  load-store broadcast, same rules
//   rs_to_alu_ready     out  1        issue valid (one cycle per op)
//   rs_to_alu_op        out  OP_W     issued opcode
//   rs_to_alu_rs1/_rs2  out  XLEN     issued operand values
//   rs_to_alu_imm/_PC   out  XLEN     issued immediate / PC
//   rs_to_alu_rob_index out  ROB_IDX_W  issued ROB index
// BEHAVIOUR
//   - Reset (rst_in=0, async): all entries free; all outputs 0; rs_full=0.
//   - Priority: reset > !rdy_in (hold everything, outputs held) > clr_in > normal.
//   - clr_in (rdy_in=1): all entries freed, rs_to_alu_ready<=0; same-cycle dispatch and CDB ignored.
//   - Dispatch: entry written into the lowest-index free slot; a dispatch while rs_full=1 is dropped.
//     The dispatcher never does this; the bench checks the drop.
//   - rs_full reflects start-of-cycle occupancy; a slot freed by issue is reusable next cycle.
//   - Wakeup: for each busy entry with qX_v=1 and qX==broadcast tag, set vX=value and qX_v<=0.
//     The ALU port is checked before the LSB port; both ports carry distinct tags.
//   - Dispatch bypass: if disp_qX matches a CDB tag in the same cycle, store the value with qX_v=0.
//   - Ready entry = busy & !qj_v & !qk_v (registered state only); a new dispatch is not eligible in its own cycle.
//   - Select: lowest-index ready entry. On the clock edge the outputs latch its fields, rs_to_alu_ready<=1,
//     and the entry is freed. With no ready entry, rs_to_alu_ready<=0 and the data outputs hold.
//   - Latency: ready-at-dispatch at edge t -> ALU inputs valid after edge t+1.
//     A CDB wakeup at edge t -> issue after edge t+1 at the earliest.
//   - Throughput: at most one issue and one dispatch per cycle; both can occur simultaneously.
//   - Outputs: rs1=vj, rs2=vk; ops that ignore rs2 dispatch with qk_v=0.
//   - Occupancy counter (0..RS_SIZE): +1 on accepted dispatch, -1 on issue; clr_in sets it to 0.
//     rs_full=(count==RS_SIZE).
// TESTING
//   - Reset then ADD vj=5 vk=7 tags invalid at cycle 0 -> cycle 2: ready=1, op=ADD, rs1=5, rs2=7; cycle 3 ready=0.
//   - SUB qj=3 pending; cdb_alu tag 3 value 0x10 two cycles later -> issued next cycle with rs1=0x10.
//     Bypass: same-cycle dispatch+CDB tag 3 -> issue 2 cycles later.
//   - Fill 8 entries all pending -> rs_full=1; 9th dispatch dropped. Broadcast frees none until issue.
//     After the first issue, rs_full=0.
//   - Entries 2 and 5 become ready in the same cycle -> entry 2 issued first, entry 5 next cycle.
//   - rdy_in=0 for 3 cycles mid-issue -> outputs and entries frozen; CDB during the stall is ignored.
//     Resume continues unchanged.
//   - clr_in with 4 busy entries and ready=1 -> next cycle ready=0, rs_full=0, no further issue.
//     rst_in low mid-run -> immediate all-zero outputs.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// Reservation station and single-issue scheduler feeding the shared integer ALU.
// Entries capture pending operands from the ALU and load-store CDB ports and
// issue lowest-index-first through registered ALU-side outputs.
module alu_issue_scheduler #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,

    input  logic                 disp_valid,
    input  logic [OP_W-1:0]      disp_op,
    input  logic [XLEN-1:0]      disp_vj,
    input  logic [XLEN-1:0]      disp_vk,
    input  logic                 disp_qj_v,
    input  logic                 disp_qk_v,
    input  logic [ROB_IDX_W-1:0] disp_qj,
    input  logic [ROB_IDX_W-1:0] disp_qk,
    input  logic [XLEN-1:0]      disp_imm,
    input  logic [XLEN-1:0]      disp_pc,
    input  logic [ROB_IDX_W-1:0] disp_rob_index,
    output logic                 rs_full,

    input  logic                 cdb_alu_valid,
    input  logic [ROB_IDX_W-1:0] cdb_alu_rob_index,
    input  logic [XLEN-1:0]      cdb_alu_value,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsb_rob_index,
    input  logic [XLEN-1:0]      cdb_lsb_value,

    output logic                 rs_to_alu_ready,
    output logic [OP_W-1:0]      rs_to_alu_op,
    output logic [XLEN-1:0]      rs_to_alu_rs1,
    output logic [XLEN-1:0]      rs_to_alu_rs2,
    output logic [XLEN-1:0]      rs_to_alu_imm,
    output logic [XLEN-1:0]      rs_to_alu_PC,
    output logic [ROB_IDX_W-1:0] rs_to_alu_rob_index
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int unsigned CNT_W = $clog2(RS_SIZE + 1);

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [XLEN-1:0]      vj;
        logic [XLEN-1:0]      vk;
        logic                 qj_v;
        logic [ROB_IDX_W-1:0] qj;
        logic                 qk_v;
        logic [ROB_IDX_W-1:0] qk;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic [ROB_IDX_W-1:0] rob;
    } entry_t;

    entry_t              ent [RS_SIZE];
    logic [RS_SIZE-1:0]  busy;
    logic [CNT_W-1:0]    count;

    logic                sel_found_c;
    logic [IDX_W-1:0]    sel_idx_c;
    logic [IDX_W-1:0]    free_idx_c;
    logic                disp_accept_c;
    entry_t              disp_entry_c;

    // Occupancy is the registered count; full blocks dispatch for the whole cycle.
    assign rs_full       = (count == CNT_W'(RS_SIZE));
    assign disp_accept_c = disp_valid && !rs_full;

    // Lowest-index ready entry to issue and lowest-index free slot to fill.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        free_idx_c  = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (busy[i] && !ent[i].qj_v && !ent[i].qk_v) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // New entry payload, with operands captured from a same-cycle broadcast.
    always_comb begin
        disp_entry_c      = '0;
        disp_entry_c.op   = disp_op;
        disp_entry_c.vj   = disp_vj;
        disp_entry_c.vk   = disp_vk;
        disp_entry_c.qj_v = disp_qj_v;
        disp_entry_c.qj   = disp_qj;
        disp_entry_c.qk_v = disp_qk_v;
        disp_entry_c.qk   = disp_qk;
        disp_entry_c.imm  = disp_imm;
        disp_entry_c.pc   = disp_pc;
        disp_entry_c.rob  = disp_rob_index;
        if (disp_qj_v) begin
            if (cdb_alu_valid && cdb_alu_rob_index == disp_qj) begin
                disp_entry_c.vj   = cdb_alu_value;
                disp_entry_c.qj_v = 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_rob_index == disp_qj) begin
                disp_entry_c.vj   = cdb_lsb_value;
                disp_entry_c.qj_v = 1'b0;
            end
        end
        if (disp_qk_v) begin
            if (cdb_alu_valid && cdb_alu_rob_index == disp_qk) begin
                disp_entry_c.vk   = cdb_alu_value;
                disp_entry_c.qk_v = 1'b0;
            end else if (cdb_lsb_valid && cdb_lsb_rob_index == disp_qk) begin
                disp_entry_c.vk   = cdb_lsb_value;
                disp_entry_c.qk_v = 1'b0;
            end
        end
    end

    // Entry storage: wakeup of pending operands, free on issue, fill on dispatch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clr_in) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (busy[i] && ent[i].qj_v) begin
                        if (cdb_alu_valid && cdb_alu_rob_index == ent[i].qj) begin
                            ent[i].vj   <= cdb_alu_value;
                            ent[i].qj_v <= 1'b0;
                        end else if (cdb_lsb_valid && cdb_lsb_rob_index == ent[i].qj) begin
                            ent[i].vj   <= cdb_lsb_value;
                            ent[i].qj_v <= 1'b0;
                        end
                    end
                    if (busy[i] && ent[i].qk_v) begin
                        if (cdb_alu_valid && cdb_alu_rob_index == ent[i].qk) begin
                            ent[i].vk   <= cdb_alu_value;
                            ent[i].qk_v <= 1'b0;
                        end else if (cdb_lsb_valid && cdb_lsb_rob_index == ent[i].qk) begin
                            ent[i].vk   <= cdb_lsb_value;
                            ent[i].qk_v <= 1'b0;
                        end
                    end
                end
                if (sel_found_c) begin
                    busy[sel_idx_c] <= 1'b0;
                end
                if (disp_accept_c) begin
                    busy[free_idx_c] <= 1'b1;
                    ent[free_idx_c]  <= disp_entry_c;
                end
            end
        end
    end

    // Occupancy counter tracking accepted dispatches minus issues.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(disp_accept_c) - CNT_W'(sel_found_c);
            end
        end
    end

    // Registered issue port; data holds when nothing issues.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rs_to_alu_ready     <= 1'b0;
            rs_to_alu_op        <= '0;
            rs_to_alu_rs1       <= '0;
            rs_to_alu_rs2       <= '0;
            rs_to_alu_imm       <= '0;
            rs_to_alu_PC        <= '0;
            rs_to_alu_rob_index <= '0;
        end else if (rdy_in) begin
            if (clr_in || !sel_found_c) begin
                rs_to_alu_ready <= 1'b0;
            end else begin
                rs_to_alu_ready     <= 1'b1;
                rs_to_alu_op        <= ent[sel_idx_c].op;
                rs_to_alu_rs1       <= ent[sel_idx_c].vj;
                rs_to_alu_rs2       <= ent[sel_idx_c].vk;
                rs_to_alu_imm       <= ent[sel_idx_c].imm;
                rs_to_alu_PC        <= ent[sel_idx_c].pc;
                rs_to_alu_rob_index <= ent[sel_idx_c].rob;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: directed scenarios plus a
// randomized run against a slot-level behavioural model.
module tb_alu_issue_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic        disp_qj_v, disp_qk_v;
    logic [3:0]  disp_qj, disp_qk, disp_rob_index;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_rob_index, cdb_lsb_rob_index;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        rs_to_alu_ready;
    logic [5:0]  rs_to_alu_op;
    logic [31:0] rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC;
    logic [3:0]  rs_to_alu_rob_index;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    alu_issue_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_v(disp_qj_v), .disp_qk_v(disp_qk_v),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_rob_index(disp_rob_index), .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_index(cdb_alu_rob_index),
        .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_index(cdb_lsb_rob_index),
        .cdb_lsb_value(cdb_lsb_value),
        .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
        .rs_to_alu_rs1(rs_to_alu_rs1), .rs_to_alu_rs2(rs_to_alu_rs2),
        .rs_to_alu_imm(rs_to_alu_imm), .rs_to_alu_PC(rs_to_alu_PC),
        .rs_to_alu_rob_index(rs_to_alu_rob_index)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj, vk, imm, pc;
        bit          qj_v, qk_v;
        logic [3:0]  qj, qk, rob;
    } m_ent_t;

    m_ent_t      m_ent [8];
    bit          m_busy [8];
    bit          m_ready;
    logic [5:0]  m_op;
    logic [31:0] m_rs1, m_rs2, m_imm, m_pc;
    logic [3:0]  m_rob;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_busy[i] ? 1 : 0;
        return n;
    endfunction

    // {still_pending, value} after looking at both broadcast ports
    function automatic logic [32:0] resolve(bit qv, logic [3:0] q, logic [31:0] v);
        if (!qv) return {1'b0, v};
        if (cdb_alu_valid && cdb_alu_rob_index == q) return {1'b0, cdb_alu_value};
        if (cdb_lsb_valid && cdb_lsb_rob_index == q) return {1'b0, cdb_lsb_value};
        return {1'b1, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
        m_ready = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0;
        m_imm = '0; m_pc = '0; m_rob = '0;
    endtask

    // One clock edge worth of behaviour, from the inputs currently driven.
    task automatic model_step();
        bit     was_busy [8];
        int     sel = -1;
        int     occ;
        logic [32:0] r;
        if (!rdy_in) return;
        if (clr_in) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
            m_ready = 0;
            return;
        end
        occ = m_count();
        for (int i = 0; i < 8; i++) was_busy[i] = m_busy[i];
        for (int i = 7; i >= 0; i--)
            if (was_busy[i] && !m_ent[i].qj_v && !m_ent[i].qk_v) sel = i;
        if (sel >= 0) begin
            m_ready = 1; m_op = m_ent[sel].op; m_rs1 = m_ent[sel].vj;
            m_rs2 = m_ent[sel].vk; m_imm = m_ent[sel].imm;
            m_pc = m_ent[sel].pc; m_rob = m_ent[sel].rob;
            m_busy[sel] = 0;
        end else begin
            m_ready = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (was_busy[i] && i != sel) begin
                r = resolve(m_ent[i].qj_v, m_ent[i].qj, m_ent[i].vj);
                m_ent[i].qj_v = r[32]; m_ent[i].vj = r[31:0];
                r = resolve(m_ent[i].qk_v, m_ent[i].qk, m_ent[i].vk);
                m_ent[i].qk_v = r[32]; m_ent[i].vk = r[31:0];
            end
        end
        if (disp_valid && occ < 8) begin
            for (int i = 0; i < 8; i++) begin
                if (!was_busy[i]) begin
                    m_ent[i].op = disp_op; m_ent[i].imm = disp_imm;
                    m_ent[i].pc = disp_pc; m_ent[i].rob = disp_rob_index;
                    m_ent[i].qj = disp_qj; m_ent[i].qk = disp_qk;
                    r = resolve(disp_qj_v, disp_qj, disp_vj);
                    m_ent[i].qj_v = r[32]; m_ent[i].vj = r[31:0];
                    r = resolve(disp_qk_v, disp_qk, disp_vk);
                    m_ent[i].qk_v = r[32]; m_ent[i].vk = r[31:0];
                    m_busy[i] = 1;
                    break;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        rdy_in = 1; clr_in = 0;
        disp_valid = 0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj_v = 0; disp_qk_v = 0; disp_qj = '0; disp_qk = '0;
        disp_imm = '0; disp_pc = '0; disp_rob_index = '0;
        cdb_alu_valid = 0; cdb_alu_rob_index = '0; cdb_alu_value = '0;
        cdb_lsb_valid = 0; cdb_lsb_rob_index = '0; cdb_lsb_value = '0;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjv, input logic [3:0] qj,
                            input logic qkv, input logic [3:0] qk, input logic [3:0] rob);
        disp_valid = 1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj_v = qjv; disp_qj = qj; disp_qk_v = qkv; disp_qk = qk;
        disp_rob_index = rob;
        disp_imm = 32'h100 + 32'(rob);
        disp_pc = 32'h8000 + {26'h0, rob, 2'b00};
    endtask

    task automatic do_reset();
        drive_idle();
        rst_in = 0;
        tick(); tick();
        rst_in = 1;
        tick();
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst_in = 0;
        tick(); tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm,
             rs_to_alu_PC, rs_to_alu_rob_index} !== '0) begin
            errors++; $display("FAIL reset_outputs: ready=%0b rs1=%h rob=%h, required all zero",
                               rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index);
        end
        checks++;
        if (rs_full !== 1'b0) begin
            errors++; $display("FAIL reset_full: got %b required 0", rs_full);
        end
        rst_in = 1;
        tick();
    endtask

    task automatic test_basic_issue();
        do_reset();
        set_disp(6'd1, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 4'd4);
        tick();
        drive_idle();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL basic_not_same_cycle: ready=%b required 0", rs_to_alu_ready);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2} !== {1'b1, 6'd1, 32'd5, 32'd7}) begin
            errors++; $display("FAIL basic_issue: ready=%b op=%0d rs1=%0d rs2=%0d required 1/1/5/7",
                               rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2);
        end
        checks++;
        if ({rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index} !== {32'h104, 32'h8010, 4'd4}) begin
            errors++; $display("FAIL basic_fields: imm=%h pc=%h rob=%0d required 104/8010/4",
                               rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rs1} !== {1'b0, 32'd5}) begin
            errors++; $display("FAIL basic_one_shot: ready=%b rs1=%0d required 0 with rs1 held at 5",
                               rs_to_alu_ready, rs_to_alu_rs1);
        end
    endtask

    task automatic test_wakeup_bypass();
        do_reset();
        set_disp(6'd2, 32'd0, 32'd3, 1, 4'd3, 0, 4'd0, 4'd1);
        tick();
        drive_idle();
        tick();
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd3; cdb_alu_value = 32'h10;
        tick();
        drive_idle();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL wakeup_early: ready=%b required 0", rs_to_alu_ready);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index} !== {1'b1, 32'h10, 32'd3, 4'd1}) begin
            errors++; $display("FAIL wakeup_issue: ready=%b rs1=%h rs2=%h rob=%0d required 1/10/3/1",
                               rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index);
        end
        set_disp(6'd2, 32'hdead, 32'hbeef, 1, 4'd3, 1, 4'd5, 4'd2);
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd3; cdb_alu_value = 32'h20;
        cdb_lsb_valid = 1; cdb_lsb_rob_index = 4'd5; cdb_lsb_value = 32'h30;
        tick();
        drive_idle();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL bypass_early: ready=%b required 0", rs_to_alu_ready);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index} !== {1'b1, 32'h20, 32'h30, 4'd2}) begin
            errors++; $display("FAIL bypass_issue: ready=%b rs1=%h rs2=%h rob=%0d required 1/20/30/2",
                               rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_rob_index);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_disp(6'd3, 32'(i), 32'd0, 1, 4'(8 + i), 0, 4'd0, 4'(i));
            tick();
        end
        checks++;
        if (rs_full !== 1'b1) begin
            errors++; $display("FAIL full_after_8: got %b required 1", rs_full);
        end
        set_disp(6'd4, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 4'd15);
        tick();
        drive_idle();
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd8; cdb_alu_value = 32'h99;
        tick();
        drive_idle();
        checks++;
        if ({rs_full, rs_to_alu_ready} !== 2'b10) begin
            errors++; $display("FAIL full_hold: full=%b ready=%b required full=1 ready=0",
                               rs_full, rs_to_alu_ready);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1, rs_full} !== {1'b1, 4'd0, 32'h99, 1'b0}) begin
            errors++; $display("FAIL full_first_issue: ready=%b rob=%0d rs1=%h full=%b required 1/0/99/0",
                               rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1, rs_full);
        end
        tick();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL full_dropped_op_issued: ready=%b rob=%0d required ready 0",
                               rs_to_alu_ready, rs_to_alu_rob_index);
        end
    endtask

    task automatic test_priority();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_disp(6'd5, 32'd0, 32'd0, 1, 4'(8 + i), 0, 4'd0, 4'(i));
            tick();
        end
        drive_idle();
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd13; cdb_alu_value = 32'h55;
        cdb_lsb_valid = 1; cdb_lsb_rob_index = 4'd10; cdb_lsb_value = 32'h22;
        tick();
        drive_idle();
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1} !== {1'b1, 4'd2, 32'h22}) begin
            errors++; $display("FAIL prio_first: ready=%b rob=%0d rs1=%h required 1/2/22",
                               rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1);
        end
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1} !== {1'b1, 4'd5, 32'h55}) begin
            errors++; $display("FAIL prio_second: ready=%b rob=%0d rs1=%h required 1/5/55",
                               rs_to_alu_ready, rs_to_alu_rob_index, rs_to_alu_rs1);
        end
        tick();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL prio_done: ready=%b required 0", rs_to_alu_ready);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_disp(6'd7, 32'd1, 32'd0, 0, 4'd0, 0, 4'd0, 4'd1);
        tick();
        set_disp(6'd7, 32'd2, 32'd0, 0, 4'd0, 0, 4'd0, 4'd2);
        tick();
        rdy_in = 0;
        set_disp(6'd8, 32'd3, 32'd0, 1, 4'd9, 0, 4'd0, 4'd3);
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd9; cdb_alu_value = 32'h77;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index} !== {1'b1, 32'd1, 4'd1}) begin
                errors++; $display("FAIL stall_frozen[%0d]: ready=%b rs1=%0d rob=%0d required 1/1/1",
                                   c, rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index);
            end
        end
        drive_idle();
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index} !== {1'b1, 32'd2, 4'd2}) begin
            errors++; $display("FAIL stall_resume: ready=%b rs1=%0d rob=%0d required 1/2/2",
                               rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index);
        end
        tick();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL stall_ignored_input: ready=%b rob=%0d required ready 0",
                               rs_to_alu_ready, rs_to_alu_rob_index);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_disp(6'd9, 32'd0, 32'd0, 1, 4'(8 + i), 0, 4'd0, 4'(i));
            tick();
        end
        set_disp(6'd9, 32'h44, 32'd0, 0, 4'd0, 0, 4'd0, 4'd4);
        tick();
        drive_idle();
        tick();
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_rob_index} !== {1'b1, 4'd4}) begin
            errors++; $display("FAIL clear_setup: ready=%b rob=%0d required 1/4",
                               rs_to_alu_ready, rs_to_alu_rob_index);
        end
        clr_in = 1;
        set_disp(6'd9, 32'h66, 32'd0, 0, 4'd0, 0, 4'd0, 4'd6);
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd8; cdb_alu_value = 32'h1;
        tick();
        drive_idle();
        checks++;
        if ({rs_to_alu_ready, rs_full} !== 2'b00) begin
            errors++; $display("FAIL clear_now: ready=%b full=%b required 0/0", rs_to_alu_ready, rs_full);
        end
        cdb_alu_valid = 1; cdb_alu_rob_index = 4'd9; cdb_alu_value = 32'h2;
        tick();
        drive_idle();
        tick();
        checks++;
        if (rs_to_alu_ready !== 1'b0) begin
            errors++; $display("FAIL clear_no_issue: ready=%b rob=%0d required ready 0",
                               rs_to_alu_ready, rs_to_alu_rob_index);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_disp(6'd10, 32'habc, 32'h1, 0, 4'd0, 0, 4'd0, 4'd7);
        tick();
        drive_idle();
        tick();
        #2;
        rst_in = 0;
        #1;
        checks++;
        if ({rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm,
             rs_to_alu_PC, rs_to_alu_rob_index, rs_full} !== '0) begin
            errors++; $display("FAIL async_reset: ready=%b rs1=%h rob=%0d required all zero",
                               rs_to_alu_ready, rs_to_alu_rs1, rs_to_alu_rob_index);
        end
        rst_in = 1;
        tick();
    endtask

    task automatic test_random();
        logic [138:0] got, exp;
        int           full_exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive_idle();
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) != 0) begin
                set_disp(6'($urandom), $urandom, $urandom,
                         1'($urandom_range(0, 1)), 4'($urandom),
                         1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
                disp_imm = $urandom; disp_pc = $urandom;
            end
            if ($urandom_range(0, 4) < 2) begin
                cdb_alu_valid = 1; cdb_alu_rob_index = 4'($urandom); cdb_alu_value = $urandom;
            end
            if ($urandom_range(0, 4) < 2) begin
                cdb_lsb_valid = 1; cdb_lsb_rob_index = 4'($urandom); cdb_lsb_value = $urandom;
                if (cdb_alu_valid && cdb_lsb_rob_index == cdb_alu_rob_index)
                    cdb_lsb_rob_index = cdb_lsb_rob_index ^ 4'd1;
            end
            model_step();
            tick();
            got = {rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
                   rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index};
            exp = {m_ready, m_op, m_rs1, m_rs2, m_imm, m_pc, m_rob};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_issue cyc %0d: got %h required %h", c, got, exp);
            end
            full_exp = (m_count() == 8) ? 1 : 0;
            checks++;
            if (rs_full !== 1'(full_exp)) begin
                errors++; $display("FAIL random_full cyc %0d: got %b required %0d", c, rs_full, full_exp);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_in = 1;
        test_reset();
        test_basic_issue();
        test_wakeup_bypass();
        test_full_drop();
        test_priority();
        test_stall();
        test_clear();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
